dma_bus_master: RTL
===================

DMA_BUS_MASTER -- requirements
Module: dma_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, the width of the bus address.
REQ-002 SHALL have parameter LEN_W, default 16, the width of the transfer byte count.
REQ-003 SHALL have parameter ROM_TOP, default 8192, the first address above the protected ROM region.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rstIn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  request pulse that launches a copy.
REQ-007 SHALL have port srcAddr  input  ADDR_W  first source byte address, sampled with start.
REQ-008 SHALL have port dstAddr  input  ADDR_W  first destination byte address, sampled with start.
REQ-009 SHALL have port length  input  LEN_W  number of bytes to copy, sampled with start.
REQ-010 SHALL have port busy  output  1  high while a copy is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  sticky abort flag, cleared by the next accepted start.
REQ-013 SHALL have port memReadWrite  output  2  bus mode: 00 RD, 01 PC (never driven), 10 WRT, 11 IDLE.
REQ-014 SHALL have port addressLinesOut  output  ADDR_W  bus address.
REQ-015 SHALL have port dataBusOut  output  8  write data.
REQ-016 SHALL have port dataIn  input  8  read data, combinationally valid in the same cycle as RD.

Function
REQ-017 SHALL implement the FSM states IDLE, RD, WR and DONE.
REQ-018 In IDLE, SHALL drive memReadWrite=11, busy=0 and done=0.
REQ-019 In IDLE, a start sampled high SHALL latch src, dst and count, clear err, and go to RD, or to DONE if length=0.
REQ-020 In RD, SHALL drive mode 00 and addressLinesOut=src, and capture dataIn into the byte buffer at the closing edge; next state is WR.
REQ-021 In WR, SHALL drive mode 10, addressLinesOut=dst and dataBusOut=buffer.
REQ-022 At the end of WR, SHALL increment src and dst, decrement count, and go to DONE if count becomes 0, else to RD.
REQ-023 In DONE, SHALL assert done=1 for exactly one cycle with mode 11, then return to IDLE.
REQ-024 busy SHALL be 1 in RD and WR only.
REQ-025 Latency: with start sampled at edge k, done SHALL be high in cycle k+1+2N for length N, and in cycle k+1 for N=0.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_W; 24'hFFFFFF+1 wraps to 0 with no error.
REQ-027 The copy SHALL always run in ascending address order; overlapping regions are copied byte by byte with no correction.
REQ-028 start while busy or in DONE SHALL be ignored and SHALL NOT affect the transfer in progress.
REQ-029 dataBusOut SHALL hold its last value outside WR; addressLinesOut SHALL be don't-care in IDLE and DONE.

Reset
REQ-030 rstIn=0 at a rising edge SHALL force IDLE, busy=0, done=0, err=0, memReadWrite=11, addressLinesOut=0, dataBusOut=0 and count=0.
REQ-031 Reset mid-transfer SHALL abort immediately with no further bus cycles; bytes already written remain written.

Configuration
REQ-032 The macro DMA_ROM_GUARD_EN SHALL control the ROM write guard.
REQ-033 With DMA_ROM_GUARD_EN defined, on entering RD with dst<ROM_TOP, SHALL issue no RD or WR for that byte, set err=1 and go to DONE (done still pulses).
REQ-034 Without DMA_ROM_GUARD_EN, err SHALL be tied 0 and any destination SHALL be writable.

Structure
REQ-035 The shared package bus_pkg SHALL hold the ADDR_MODE_RD/PC/WRT/IDLE encodings, the ROM_TOP default and the DMA state encoding, shared with the memory/IO responder and Control.
REQ-036 SHALL be a single module with no sub-modules; the FSM, counters and buffer are too small to split.

Verification
REQ-037 Scenario: src=0x2000, dst=0x3000, len=3, memory 0x2000..2=AA,BB,CC -> bus sequence RD2000, WR3000=AA, RD2001, WR3001=BB, RD2002, WR3002=CC; done in cycle k+7.
REQ-038 Scenario: len=0 -> no mode 00 or 10 cycles; done in cycle k+1; busy never high.
REQ-039 Scenario: src=0xFFFFFF, dst=0x4000, len=2 -> reads FFFFFF then 000000; no err.
REQ-040 Scenario: rstIn low during second WR of len=4 -> next cycle mode=11 and busy=0; only byte 0 written; no done pulse.
REQ-041 Scenario (guard on): dst=0x1FFF, len=2 -> no bus cycles, err=1, done pulse; a new start then clears err.
REQ-042 Scenario: start pulsed again mid-copy with different addresses -> original transfer completes unchanged.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus encodings, ROM boundary default and DMA state encoding used by the
// DMA master, the memory/IO responder and Control.
package bus_pkg;

  localparam logic [1:0] ADDR_MODE_RD   = 2'b00;
  localparam logic [1:0] ADDR_MODE_PC   = 2'b01;
  localparam logic [1:0] ADDR_MODE_WRT  = 2'b10;
  localparam logic [1:0] ADDR_MODE_IDLE = 2'b11;

  localparam int unsigned ROM_TOP_DEFAULT = 8192;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_RD   = 2'd1,
    DMA_WR   = 2'd2,
    DMA_DONE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_bus_master.sv
// Byte-at-a-time memory-to-memory copy engine: one RD cycle then one WR cycle per byte.
// Optional ROM write guard enabled by defining DMA_ROM_GUARD_EN.
module dma_bus_master
  import bus_pkg::*;
#(
  parameter int          ADDR_W  = 24,
  parameter int          LEN_W   = 16,
  parameter int unsigned ROM_TOP = ROM_TOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rstIn,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        memReadWrite,
  output logic [ADDR_W-1:0] addressLinesOut,
  output logic [7:0]        dataBusOut,
  input  logic [7:0]        dataIn,
  output logic [1:0]        o_dbg_state
);

`ifdef DMA_ROM_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  dma_state_t        r_state;
  dma_state_t        w_next_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_count;
  logic [7:0]        r_buf;
  logic              r_err;

  logic [ADDR_W-1:0] w_src_inc;
  logic [ADDR_W-1:0] w_dst_inc;
  logic              w_last;
  logic              w_len_zero;
  logic              w_start_rom_hit;
  logic              w_next_rom_hit;

  // Increments wrap naturally at ADDR_W bits.
  assign w_src_inc       = r_src + 1'b1;
  assign w_dst_inc       = r_dst + 1'b1;
  assign w_last          = (r_count == LEN_W'(1));
  assign w_len_zero      = (length == '0);
  assign w_start_rom_hit = GUARD_EN && (dstAddr < ADDR_W'(ROM_TOP));
  assign w_next_rom_hit  = GUARD_EN && (w_dst_inc < ADDR_W'(ROM_TOP));

  // start is a single-cycle request with no ready: it is only looked at in
  // IDLE, and a pulse seen in RD/WR/DONE is dropped without side effects.
  always_ff @(posedge clk) begin
    if (!rstIn) r_state <= DMA_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DMA_IDLE: begin
        if (start) begin
          if (w_len_zero || w_start_rom_hit) w_next_state = DMA_DONE;
          else                               w_next_state = DMA_RD;
        end
      end
      DMA_RD:   w_next_state = DMA_WR;
      DMA_WR: begin
        if (w_last || w_next_rom_hit) w_next_state = DMA_DONE;
        else                          w_next_state = DMA_RD;
      end
      DMA_DONE: w_next_state = DMA_IDLE;
      default:  w_next_state = DMA_IDLE;
    endcase
  end

  always_comb begin
    memReadWrite    = ADDR_MODE_IDLE;
    addressLinesOut = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (r_state)
      DMA_RD: begin
        memReadWrite    = ADDR_MODE_RD;
        addressLinesOut = r_src;
        busy            = 1'b1;
      end
      DMA_WR: begin
        memReadWrite    = ADDR_MODE_WRT;
        addressLinesOut = r_dst;
        busy            = 1'b1;
      end
      DMA_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstIn) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        DMA_IDLE: begin
          if (start) begin
            r_src   <= srcAddr;
            r_dst   <= dstAddr;
            r_count <= length;
            r_err   <= w_start_rom_hit && !w_len_zero;
          end
        end
        DMA_RD: r_buf <= dataIn;
        DMA_WR: begin
          r_src   <= w_src_inc;
          r_dst   <= w_dst_inc;
          r_count <= r_count - 1'b1;
          if (!w_last && w_next_rom_hit) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The buffer only changes at the end of RD, so the write bus holds between WRs.
  assign dataBusOut  = r_buf;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule
